// File: rtl/apple_spawner.sv
// Apple relocation for the snake game: on each eat, searches an LFSR-driven free cell
// (with a deterministic fallback), pulses grow and advances a saturating 4-digit BCD score.
module apple_spawner #(
  parameter int          CELL      = 10,
  parameter int          GRID_W    = 64,
  parameter int          GRID_H    = 48,
  parameter int          INIT_COL  = 30,
  parameter int          INIT_ROW  = 20,
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int          MAX_TRIES = 16
) (
  input  logic        clk_pix,
  input  logic        reset_n,
  input  logic        eat_evt,
  input  logic [9:0]  head_x,
  input  logic [8:0]  head_y,
  output logic [9:0]  apple_x,
  output logic [8:0]  apple_y,
  output logic        apple_valid,
  output logic        busy,
  output logic        grow,
  output logic [15:0] score,
  output logic [15:0] lfsr_dbg
);

  localparam logic [15:0]      LFSR_MASK = 16'hB400;
  localparam int               TRY_W     = $clog2(MAX_TRIES + 1);
  localparam logic [TRY_W-1:0] LAST_TRY  = TRY_W'(MAX_TRIES - 1);
  localparam logic [9:0]       CELL_X    = 10'(CELL);
  localparam logic [8:0]       CELL_Y    = 9'(CELL);
  localparam logic [6:0]       GRID_W_C  = 7'(GRID_W);
  localparam logic [6:0]       GRID_H_C  = 7'(GRID_H);
  localparam logic [7:0]       WRAP_W    = 8'(GRID_W);
  localparam logic [7:0]       HALF_W    = 8'(GRID_W / 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAW,
    S_CHECK,
    S_FALLBACK,
    S_COMMIT
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [15:0]      r_lfsr;
  logic [15:0]      r_score;
  logic             r_grow;
  logic [TRY_W-1:0] r_tries;
  logic [9:0]       r_apple_x;
  logic [8:0]       r_apple_y;
  logic [5:0]       r_cand_col;
  logic [5:0]       r_cand_row;
  logic [9:0]       r_cand_px;
  logic [8:0]       r_cand_py;
  logic [9:0]       r_sel_px;
  logic [8:0]       r_sel_py;
  logic [9:0]       r_rem_x;
  logic [8:0]       r_rem_y;
  logic [6:0]       r_fb_col;
  logic [5:0]       r_fb_row;

  logic [9:0] w_draw_px;
  logic [8:0] w_draw_py;
  logic       w_reject;
  logic       w_last_try;
  logic       w_fb_x_done;
  logic       w_fb_y_done;
  logic [7:0] w_fb_sum;
  logic [7:0] w_fb_col;
  logic [9:0] w_fb_px;
  logic [8:0] w_fb_py;
  logic       w_accept_eat;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    if (v == 16'h9999) return v;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (r[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          c           = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign w_draw_px    = CELL_X * {4'd0, r_lfsr[5:0]};
  assign w_draw_py    = CELL_Y * {3'd0, r_lfsr[11:6]};
  assign w_reject     = ({1'b0, r_cand_col} >= GRID_W_C) ||
                        ({1'b0, r_cand_row} >= GRID_H_C) ||
                        ((r_cand_px == head_x) && (r_cand_py == head_y));
  assign w_last_try   = (r_tries == LAST_TRY);
  assign w_accept_eat = (r_state == S_IDLE) && eat_evt;

  // Fallback divides the head position by CELL with a repeated-subtract loop.
  assign w_fb_x_done = (r_rem_x < CELL_X);
  assign w_fb_y_done = (r_rem_y < CELL_Y);
  assign w_fb_sum    = {1'b0, r_fb_col} + HALF_W;
  assign w_fb_col    = (w_fb_sum >= WRAP_W) ? (w_fb_sum - WRAP_W) : w_fb_sum;
  assign w_fb_px     = CELL_X * {2'd0, w_fb_col};
  assign w_fb_py     = CELL_Y * {3'd0, r_fb_row};

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk_pix or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  // NOTE: default assignment first so no path through the case leaves a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:     if (eat_evt) w_next_state = S_DRAW;
      S_DRAW:     w_next_state = S_CHECK;
      S_CHECK: begin
        if (!w_reject)      w_next_state = S_COMMIT;
        else if (w_last_try) w_next_state = S_FALLBACK;
        else                w_next_state = S_DRAW;
      end
      S_FALLBACK: if (w_fb_x_done && w_fb_y_done) w_next_state = S_COMMIT;
      S_COMMIT:   w_next_state = S_IDLE;
      default:    w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    apple_valid = 1'b0;
    busy        = 1'b0;
    if (r_state == S_IDLE) apple_valid = 1'b1;
    else                   busy        = 1'b1;
  end

  always_ff @(posedge clk_pix or negedge reset_n) begin
    if (!reset_n) begin
      r_lfsr     <= SEED;
      r_score    <= 16'h0000;
      r_grow     <= 1'b0;
      r_tries    <= '0;
      r_apple_x  <= 10'(INIT_COL * CELL);
      r_apple_y  <= 9'(INIT_ROW * CELL);
      r_cand_col <= 6'd0;
      r_cand_row <= 6'd0;
      r_cand_px  <= 10'd0;
      r_cand_py  <= 9'd0;
      r_sel_px   <= 10'd0;
      r_sel_py   <= 9'd0;
      r_rem_x    <= 10'd0;
      r_rem_y    <= 9'd0;
      r_fb_col   <= 7'd0;
      r_fb_row   <= 6'd0;
    end else begin
      r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_MASK : 16'h0000);
      r_grow <= w_accept_eat;
      if (w_accept_eat) begin
        r_score <= bcd_inc(r_score);
        r_tries <= '0;
      end
      case (r_state)
        S_DRAW: begin
          r_cand_col <= r_lfsr[5:0];
          r_cand_row <= r_lfsr[11:6];
          r_cand_px  <= w_draw_px;
          r_cand_py  <= w_draw_py;
        end
        S_CHECK: begin
          if (!w_reject) begin
            r_sel_px <= r_cand_px;
            r_sel_py <= r_cand_py;
          end else if (w_last_try) begin
            r_rem_x  <= head_x;
            r_rem_y  <= head_y;
            r_fb_col <= 7'd0;
            r_fb_row <= 6'd0;
          end else begin
            r_tries <= r_tries + 1'b1;
          end
        end
        S_FALLBACK: begin
          if (!w_fb_x_done) begin
            r_rem_x  <= r_rem_x - CELL_X;
            r_fb_col <= r_fb_col + 7'd1;
          end
          if (!w_fb_y_done) begin
            r_rem_y  <= r_rem_y - CELL_Y;
            r_fb_row <= r_fb_row + 6'd1;
          end
          if (w_fb_x_done && w_fb_y_done) begin
            r_sel_px <= w_fb_px;
            r_sel_py <= w_fb_py;
          end
        end
        S_COMMIT: begin
          r_apple_x <= r_sel_px;
          r_apple_y <= r_sel_py;
        end
        default: ;
      endcase
    end
  end

  assign apple_x  = r_apple_x;
  assign apple_y  = r_apple_y;
  assign grow     = r_grow;
  assign score    = r_score;
  assign lfsr_dbg = r_lfsr;

endmodule
